io_input_debounce: RTL

//  Conditions the two memory-mapped input ports (switch/button banks) before they reach the

---
 rtl/io_input_debounce_pkg.sv | 41 ++++
 rtl/io_input_debounce_db_bit.sv | 91 +++++++++
 rtl/io_input_debounce.sv | 48 ++++
 3 files changed

// File: rtl/io_input_debounce_pkg.sv
// Shared constants and types for the memory-mapped input conditioning block.
// Holds the IO address map, the default sizing of the debounce path, and the
// small helpers used when sizing the per-bit stability counter.
package io_input_debounce_pkg;

  // Data-RAM addresses of the memory-mapped IO ports.
  localparam logic [7:0] IOA_ADDR = 8'd248;
  localparam logic [7:0] IOB_ADDR = 8'd249;
  localparam logic [7:0] IOC_ADDR = 8'd250;
  localparam logic [7:0] IOD_ADDR = 8'd251;
  localparam logic [7:0] IOE_ADDR = 8'd252;
  localparam logic [7:0] IOF_ADDR = 8'd253;
  localparam logic [7:0] IOG_ADDR = 8'd254;
  localparam logic [7:0] IOH_ADDR = 8'd255;

  // Default sizing of the input conditioning path.
  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DB_CYCLES   = 4;

  // What the debounce decision does with a bit on a given edge.
  //   DB_IDLE   : synced value matches the stable value, counter is cleared
  //   DB_COUNT  : mismatch still too short, counter advances
  //   DB_ACCEPT : mismatch held long enough, stable value takes the synced one
  typedef enum logic [1:0] {
    DB_IDLE   = 2'd0,
    DB_COUNT  = 2'd1,
    DB_ACCEPT = 2'd2
  } db_action_e;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/io_input_debounce_db_bit.sv
// One-bit input conditioner: a synchronizer chain followed by a stability
// counter. The stable value only moves after the synced input has disagreed
// with it for DB_CYCLES consecutive edges; any return to the stable value in
// between throws the partial count away. CHG is a registered one-cycle pulse
// aligned with the first cycle the new stable value is visible on Q.
module io_input_debounce_db_bit
  import io_input_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  output logic Q,
  output logic CHG
);

  localparam int unsigned CW = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   stb_q;
  logic                   stb_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   chg_q;
  logic                   chg_d;
  logic                   s;
  db_action_e             act;

  // Synchronizer output is the oldest stage of the shift chain.
  assign s = sync_q[SYNC_STAGES-1];

  // Classify this edge: hold, keep counting, or accept the new value.
  always_comb begin
    act = DB_IDLE;
    if (s != stb_q) begin
      // >= rather than == so a corrupted counter can never stall the bit.
      if (cnt_q >= CNT_LAST) begin
        act = DB_ACCEPT;
      end else begin
        act = DB_COUNT;
      end
    end
  end

  // Next-state values for the chain, counter, stable value and change pulse.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], D};
    stb_d  = stb_q;
    cnt_d  = '0;
    chg_d  = 1'b0;
    unique case (act)
      DB_IDLE: begin
        cnt_d = '0;
      end
      DB_COUNT: begin
        cnt_d = cnt_q + 1'b1;
      end
      DB_ACCEPT: begin
        stb_d = s;
        cnt_d = '0;
        chg_d = 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // State registers; synchronous reset discards any partial count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      stb_q  <= 1'b0;
      cnt_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      stb_q  <= stb_d;
      cnt_q  <= cnt_d;
      chg_q  <= chg_d;
    end
  end

  assign Q   = stb_q;
  assign CHG = chg_q;

endmodule

// File: rtl/io_input_debounce.sv
// Conditions the two switch/button banks feeding the data-RAM read mux as
// IOA and IOB. Every bit of both banks gets its own independent conditioner,
// so any combination of bits may change, and pulse CHG, on the same cycle.
// All outputs come straight from flops inside the per-bit conditioners.
module io_input_debounce
  import io_input_debounce_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW_A,
  input  logic [WIDTH-1:0] SW_B,
  output logic [WIDTH-1:0] IOA,
  output logic [WIDTH-1:0] IOB,
  output logic [WIDTH-1:0] CHG_A,
  output logic [WIDTH-1:0] CHG_B
);

  // Bank A occupies the low half, bank B the high half.
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] stb;
  logic [2*WIDTH-1:0] chg;

  assign raw = {SW_B, SW_A};

  // One conditioner per input bit across both banks.
  for (genvar i = 0; i < 2*WIDTH; i++) begin : g_bit
    io_input_debounce_db_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db_bit (
      .CLK   (CLK),
      .RESET (RESET),
      .D     (raw[i]),
      .Q     (stb[i]),
      .CHG   (chg[i])
    );
  end

  assign IOA   = stb[WIDTH-1:0];
  assign IOB   = stb[2*WIDTH-1:WIDTH];
  assign CHG_A = chg[WIDTH-1:0];
  assign CHG_B = chg[2*WIDTH-1:WIDTH];

endmodule
